// File: rtl/nand_dq_delay_calib_pkg.sv
// Shared definitions for the NAND PHY DQ input-delay calibration.
//   - Calibration FSM state encoding.
//   - Default widths, timing constants and the training word. The IODELAY
//     instantiation uses the same tap-count constants.
package nand_dq_delay_calib_pkg;

    localparam int unsigned DEF_DQ_W        = 8;
    localparam int unsigned DEF_TAP_W       = 5;
    localparam int unsigned DEF_NUM_TAPS    = 1 << DEF_TAP_W;
    localparam int unsigned DEF_SETTLE_CYC  = 16;
    localparam int unsigned DEF_NUM_SAMPLES = 64;
    localparam int unsigned DEF_TIMEOUT_CYC = 1024;
    localparam int unsigned DEF_MIN_WIN     = 4;
    localparam logic [7:0]  DEF_EXP_PATTERN = 8'hA5;

    typedef enum logic [3:0] {
        StIdle,
        StTapRst,
        StSettle,
        StSample,
        StEval,
        StStep,
        StCtrRst,
        StCtrStep,
        StCtrSettle,
        StDone,
        StErr
    } calib_state_e;

endpackage

// File: rtl/nand_dq_delay_calib_sampler.sv
// Per-tap training-read checker.
//   clk0, rst0   clock, async active-high reset
//   clear        hold both counters at 0 (asserted whenever the FSM is not sampling)
//   rd_data      captured DQ word
//   rd_valid     rd_data valid this cycle
//   pass         NUM_SAMPLES matching valid words seen (1-cycle pulse)
//   fail         mismatch on a valid word, or TIMEOUT_CYC cycles without passing
module nand_dq_delay_calib_sampler #(
    parameter int unsigned DQ_W        = 8,
    parameter int unsigned NUM_SAMPLES = 64,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [DQ_W-1:0] EXP_PATTERN = 8'hA5
) (
    input  logic            clk0,
    input  logic            rst0,
    input  logic            clear,
    input  logic [DQ_W-1:0] rd_data,
    input  logic            rd_valid,
    output logic            pass,
    output logic            fail
);

    localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] samp_cnt_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          match;
    logic          samp_last;
    logic          tmo_last;

    assign match     = (rd_data == EXP_PATTERN);
    assign samp_last = rd_valid && match && (samp_cnt_q == CW'(NUM_SAMPLES - 1));
    assign tmo_last  = (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

    // Completing the sample count on the final timeout cycle still counts as a pass.
    assign pass = !clear && samp_last;
    assign fail = !clear && !samp_last && ((rd_valid && !match) || tmo_last);

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            samp_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else if (clear) begin
            samp_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            if (rd_valid && match) begin
                samp_cnt_q <= samp_cnt_q + CW'(1);
            end
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/nand_dq_delay_calib.sv
// Post-reset DQ input-delay calibration for the NAND PHY.
// Sweeps the DQ IODELAY across all taps, finds the first passing window of
// at least MIN_WIN taps and parks the delay at the window centre.
//   clk0, rst0          PHY clock, async active-high reset
//   start               1-cycle pulse: begin (or re-run) calibration when not busy
//   rd_data, rd_valid   captured training word and its valid strobe
//   pat_req             controller must stream training reads while high
//   dly_rst             IODELAY load-to-tap-0 pulse
//   dly_ce, dly_inc     IODELAY step pulse and direction (always increment)
//   tap_cur             tap currently programmed into the IODELAY
//   win_start, win_end  accepted window bounds
//   busy, done, err     status to the NAND controller
module nand_dq_delay_calib
    import nand_dq_delay_calib_pkg::*;
#(
    parameter int unsigned DQ_W        = DEF_DQ_W,
    parameter int unsigned TAP_W       = DEF_TAP_W,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned MIN_WIN     = DEF_MIN_WIN,
    parameter logic [DQ_W-1:0] EXP_PATTERN = DEF_EXP_PATTERN
) (
    input  logic             clk0,
    input  logic             rst0,
    input  logic             start,
    input  logic [DQ_W-1:0]  rd_data,
    input  logic             rd_valid,
    output logic             pat_req,
    output logic             dly_rst,
    output logic             dly_ce,
    output logic             dly_inc,
    output logic [TAP_W-1:0] tap_cur,
    output logic [TAP_W-1:0] win_start,
    output logic [TAP_W-1:0] win_end,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned NUM_TAPS = 1 << TAP_W;
    localparam int unsigned SW       = $clog2(SETTLE_CYC + 1);
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [TAP_W:0]   MIN_WIN_L   = (TAP_W + 1)'(MIN_WIN);

    calib_state_e     state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             run_open_q, run_open_d;
    logic [TAP_W-1:0] run_start_q, run_start_d;
    logic [TAP_W-1:0] win_start_q, win_start_d;
    logic [TAP_W-1:0] win_end_q, win_end_d;
    logic             tap_pass_q, tap_pass_d;

    logic             samp_clear;
    logic             samp_pass;
    logic             samp_fail;
    logic [TAP_W-1:0] eval_start;
    logic [TAP_W:0]   close_len;
    logic [TAP_W:0]   run_len;
    logic [TAP_W:0]   win_sum;
    logic [TAP_W-1:0] centre;

    assign samp_clear = (state_q != StSample);

    nand_dq_delay_calib_sampler #(
        .DQ_W        (DQ_W),
        .NUM_SAMPLES (NUM_SAMPLES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .EXP_PATTERN (EXP_PATTERN)
    ) u_sampler (
        .clk0     (clk0),
        .rst0     (rst0),
        .clear    (samp_clear),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .pass     (samp_pass),
        .fail     (samp_fail)
    );

    // A passing tap either extends the open run or opens a new one here.
    assign eval_start = run_open_q ? run_start_q : tap_q;
    // Run closed by the last tap passing: it includes that tap.
    assign close_len  = (TAP_W + 1)'(NUM_TAPS) - {1'b0, eval_start};
    // Run closed by a failing tap: it ends one tap before.
    assign run_len    = {1'b0, tap_q} - {1'b0, run_start_q};
    assign win_sum    = {1'b0, win_start_q} + {1'b0, win_end_q};
    assign centre     = win_sum[TAP_W:1];

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        settle_d    = '0;
        run_open_d  = run_open_q;
        run_start_d = run_start_q;
        win_start_d = win_start_q;
        win_end_d   = win_end_q;
        tap_pass_d  = tap_pass_q;
        pat_req     = 1'b0;
        dly_rst     = 1'b0;
        dly_ce      = 1'b0;

        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StTapRst;
                end
            end
            StTapRst: begin
                dly_rst     = 1'b1;
                tap_d       = '0;
                run_open_d  = 1'b0;
                win_start_d = '0;
                win_end_d   = '0;
                state_d     = StSettle;
            end
            StSettle, StCtrSettle: begin
                settle_d = settle_q + SW'(1);
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = (state_q == StSettle) ? StSample : StDone;
                end
            end
            StSample: begin
                pat_req = 1'b1;
                if (samp_pass) begin
                    tap_pass_d = 1'b1;
                    state_d    = StEval;
                end else if (samp_fail) begin
                    tap_pass_d = 1'b0;
                    state_d    = StEval;
                end
            end
            StEval: begin
                if (tap_pass_q) begin
                    run_open_d  = 1'b1;
                    run_start_d = eval_start;
                    if (tap_q == LAST_TAP) begin
                        if (close_len >= MIN_WIN_L) begin
                            win_start_d = eval_start;
                            win_end_d   = LAST_TAP;
                            state_d     = StCtrRst;
                        end else begin
                            state_d = StErr;
                        end
                    end else begin
                        state_d = StStep;
                    end
                end else begin
                    if (run_open_q && (run_len >= MIN_WIN_L)) begin
                        win_start_d = run_start_q;
                        win_end_d   = tap_q - TAP_W'(1);
                        state_d     = StCtrRst;
                    end else begin
                        run_open_d = 1'b0;
                        state_d    = (tap_q == LAST_TAP) ? StErr : StStep;
                    end
                end
            end
            StStep: begin
                dly_ce  = 1'b1;
                tap_d   = tap_q + TAP_W'(1);
                state_d = StSettle;
            end
            StCtrRst: begin
                dly_rst = 1'b1;
                tap_d   = '0;
                state_d = StCtrStep;
            end
            StCtrStep: begin
                if (tap_q == centre) begin
                    state_d = StCtrSettle;
                end else begin
                    dly_ce = 1'b1;
                    tap_d  = tap_q + TAP_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign dly_inc   = dly_ce;
    assign tap_cur   = tap_q;
    assign win_start = win_start_q;
    assign win_end   = win_end_q;
    assign done      = (state_q == StDone);
    assign err       = (state_q == StErr);
    assign busy      = !(state_q == StIdle || state_q == StDone || state_q == StErr);

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_q     <= StIdle;
            tap_q       <= '0;
            settle_q    <= '0;
            run_open_q  <= 1'b0;
            run_start_q <= '0;
            win_start_q <= '0;
            win_end_q   <= '0;
            tap_pass_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            settle_q    <= settle_d;
            run_open_q  <= run_open_d;
            run_start_q <= run_start_d;
            win_start_q <= win_start_d;
            win_end_q   <= win_end_d;
            tap_pass_q  <= tap_pass_d;
        end
    end

endmodule

// File: tb/tb_nand_dq_delay_calib.sv
// Bench for nand_dq_delay_calib: an IODELAY/controller model answers training
// reads from a per-tap pass mask; expected calibration results are queued per
// run and compared when done or err rises.
module tb_nand_dq_delay_calib;

    localparam int BUDGET = 6000;

    typedef struct {
        logic [4:0] ws;
        logic [4:0] we;
        logic [4:0] tap;
        logic       done;
        logic       err;
        logic       chk_win;
        int         ces;
        int         rsts;
        int         per_tap;
        int         per_cyc;
    } exp_t;

    logic       clk0;
    logic       rst0;
    logic       start;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       pat_req;
    logic       dly_rst;
    logic       dly_ce;
    logic       dly_inc;
    logic [4:0] tap_cur;
    logic [4:0] win_start;
    logic [4:0] win_end;
    logic       busy;
    logic       done;
    logic       err;

    nand_dq_delay_calib dut (
        .clk0      (clk0),
        .rst0      (rst0),
        .start     (start),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .pat_req   (pat_req),
        .dly_rst   (dly_rst),
        .dly_ce    (dly_ce),
        .dly_inc   (dly_inc),
        .tap_cur   (tap_cur),
        .win_start (win_start),
        .win_end   (win_end),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Scoreboard and stimulus settings (written by the main process only).
    exp_t        sb[$];
    logic [31:0] mask;
    int          hold_tap;
    int          n_pass;
    int          n_total;

    // Model state (written by the model process only).
    int model_tap;
    int cyc;
    int run_rst;
    int ce_since_rst;
    int hazard;
    int ce_cycle[32];

    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    // IODELAY + controller model, evaluated mid-cycle.
    initial begin
        model_tap    = 0;
        cyc          = 0;
        run_rst      = 0;
        ce_since_rst = 0;
        hazard       = 0;
        rd_valid     = 1'b0;
        rd_data      = 8'h00;
        for (int i = 0; i < 32; i++) ce_cycle[i] = 0;
        forever begin
            @(negedge clk0);
            cyc++;
            if (rst0) model_tap = 0;
            if (tap_cur !== model_tap[4:0]) hazard++;
            if (dly_rst && dly_ce) hazard++;
            if (dly_ce && !dly_inc) hazard++;
            if (start && !busy) run_rst = 0;
            if (pat_req === 1'b1) begin
                rd_valid = (model_tap != hold_tap);
                rd_data  = (model_tap < 32 && mask[model_tap]) ? 8'hA5 : 8'h5A;
            end else begin
                rd_valid = 1'b0;
                rd_data  = 8'h00;
            end
            if (dly_rst === 1'b1) begin
                run_rst++;
                ce_since_rst = 0;
                model_tap    = 0;
            end else if (dly_ce === 1'b1) begin
                if (run_rst == 1 && model_tap < 32) ce_cycle[model_tap] = cyc;
                ce_since_rst++;
                model_tap++;
                if (model_tap > 31) hazard++;
            end
        end
    end

    function automatic logic [31:0] mk(input int lo, input int hi);
        logic [31:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic test_reset;
        logic [28:0] obs;
        rst0  = 1'b0;
        start = 1'b0;
        mask  = '0;
        hold_tap = -1;
        #2 rst0 = 1'b1;
        #1;
        obs = {pat_req, dly_rst, dly_ce, dly_inc, busy, done, err, tap_cur, win_start, win_end};
        n_total++;
        if (obs !== 29'd0) $display("FAIL reset_outputs: got %h want 0", obs);
        else n_pass++;
        repeat (3) @(posedge clk0);
        #1 rst0 = 1'b0;
        repeat (3) @(posedge clk0);
        #1;
        obs = {pat_req, dly_rst, dly_ce, dly_inc, busy, done, err, tap_cur, win_start, win_end};
        n_total++;
        if (obs !== 29'd0) $display("FAIL idle_after_reset: got %h want 0", obs);
        else n_pass++;
    endtask

    task automatic test_sweep(input string name, input logic [31:0] m, input int hold,
                              input bit poke, input exp_t e);
        exp_t x;
        int   n;
        logic [4:0] tap_hold;
        mask     = m;
        hold_tap = hold;
        sb.push_back(e);
        @(posedge clk0);
        #1 start = 1'b1;
        @(posedge clk0);
        #1 start = 1'b0;
        n_total++;
        if ({dly_rst, busy, done, err} !== 4'b1100)
            $display("FAIL %s start_ack: got %b want 1100", name, {dly_rst, busy, done, err});
        else n_pass++;

        n = 0;
        while (!(done === 1'b1 || err === 1'b1) && n < BUDGET) begin
            @(posedge clk0);
            #1;
            start = poke && (n == 50 || n == 300 || n == 700);
            n++;
        end
        start = 1'b0;
        x = sb.pop_front();
        n_total++;
        if (n >= BUDGET) begin
            $display("FAIL %s timeout: got no done/err within %0d cycles", name, BUDGET);
        end else begin
            n_pass++;
            n_total++;
            if ({done, err, busy, pat_req} !== {x.done, x.err, 2'b00})
                $display("FAIL %s status: got %b want %b", name,
                         {done, err, busy, pat_req}, {x.done, x.err, 2'b00});
            else n_pass++;
            n_total++;
            if (tap_cur !== x.tap) $display("FAIL %s tap_cur: got %0d want %0d", name, tap_cur, x.tap);
            else n_pass++;
            if (x.chk_win) begin
                n_total++;
                if ({win_start, win_end} !== {x.ws, x.we})
                    $display("FAIL %s window: got %0d..%0d want %0d..%0d", name,
                             win_start, win_end, x.ws, x.we);
                else n_pass++;
            end
            n_total++;
            if (ce_since_rst != x.ces)
                $display("FAIL %s ce_after_rst: got %0d want %0d", name, ce_since_rst, x.ces);
            else n_pass++;
            n_total++;
            if (run_rst != x.rsts)
                $display("FAIL %s dly_rst_count: got %0d want %0d", name, run_rst, x.rsts);
            else n_pass++;
            n_total++;
            if (hazard != 0) $display("FAIL %s pulse_or_tap_hazards: got %0d want 0", name, hazard);
            else n_pass++;
            if (x.per_tap > 0) begin
                n_total++;
                if (ce_cycle[x.per_tap] - ce_cycle[x.per_tap - 1] != x.per_cyc)
                    $display("FAIL %s tap%0d_latency: got %0d want %0d", name, x.per_tap,
                             ce_cycle[x.per_tap] - ce_cycle[x.per_tap - 1], x.per_cyc);
                else n_pass++;
            end
            tap_hold = tap_cur;
            repeat (5) @(posedge clk0);
            #1;
            n_total++;
            if ({done, err, tap_cur} !== {x.done, x.err, tap_hold})
                $display("FAIL %s sticky: got %b want %b", name, {done, err, tap_cur},
                         {x.done, x.err, tap_hold});
            else n_pass++;
        end
    endtask

    task automatic test_reset_midrun(input exp_t e);
        logic [28:0] obs;
        int n;
        mask     = mk(10, 20);
        hold_tap = -1;
        @(posedge clk0);
        #1 start = 1'b1;
        @(posedge clk0);
        #1 start = 1'b0;
        n = 0;
        while (!(tap_cur === 5'd12 && pat_req === 1'b1) && n < BUDGET) begin
            @(posedge clk0);
            #1;
            n++;
        end
        n_total++;
        if (n >= BUDGET) $display("FAIL midrun_reach_tap12: got no SAMPLE at tap 12");
        else n_pass++;
        repeat (10) @(posedge clk0);
        #3 rst0 = 1'b1;
        #1;
        obs = {pat_req, dly_rst, dly_ce, dly_inc, busy, done, err, tap_cur, win_start, win_end};
        n_total++;
        if (obs !== 29'd0) $display("FAIL midrun_reset_outputs: got %h want 0", obs);
        else n_pass++;
        repeat (2) @(posedge clk0);
        #1;
        obs = {pat_req, dly_rst, dly_ce, dly_inc, busy, done, err, tap_cur, win_start, win_end};
        n_total++;
        if (obs !== 29'd0) $display("FAIL midrun_reset_held: got %h want 0", obs);
        else n_pass++;
        rst0 = 1'b0;
        test_sweep("after_reset", mk(10, 20), -1, 1'b1, e);
    endtask

    initial begin
        exp_t e;
        n_pass  = 0;
        n_total = 0;
        test_reset;

        e = '{ws: 5'd10, we: 5'd20, tap: 5'd15, done: 1'b1, err: 1'b0, chk_win: 1'b1,
              ces: 15, rsts: 2, per_tap: 10, per_cyc: 82};
        test_sweep("mid_window", mk(10, 20), -1, 1'b0, e);

        e = '{ws: 5'd8, we: 5'd13, tap: 5'd10, done: 1'b1, err: 1'b0, chk_win: 1'b1,
              ces: 10, rsts: 2, per_tap: -1, per_cyc: 0};
        test_sweep("short_run_discarded", mk(3, 4) | mk(8, 13), -1, 1'b0, e);

        e = '{ws: 5'd25, we: 5'd31, tap: 5'd28, done: 1'b1, err: 1'b0, chk_win: 1'b1,
              ces: 28, rsts: 2, per_tap: -1, per_cyc: 0};
        test_sweep("window_at_top", mk(25, 31), -1, 1'b0, e);

        e = '{ws: 5'd0, we: 5'd0, tap: 5'd31, done: 1'b0, err: 1'b1, chk_win: 1'b0,
              ces: 31, rsts: 1, per_tap: -1, per_cyc: 0};
        test_sweep("all_fail", 32'h0, -1, 1'b0, e);

        e = '{ws: 5'd6, we: 5'd9, tap: 5'd7, done: 1'b1, err: 1'b0, chk_win: 1'b1,
              ces: 7, rsts: 2, per_tap: 5, per_cyc: 1042};
        test_sweep("timeout_tap5", mk(2, 9), 5, 1'b0, e);

        e = '{ws: 5'd10, we: 5'd20, tap: 5'd15, done: 1'b1, err: 1'b0, chk_win: 1'b1,
              ces: 15, rsts: 2, per_tap: 10, per_cyc: 82};
        test_reset_midrun(e);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
